// File: rtl/axis_xor_cipher.sv
// axis_xor_cipher: AXI4-Stream XOR cipher with header skip, per-packet key/mode latch and encrypted-packet counter
module axis_xor_cipher #(
    parameter int C_AXIS_DATA_WIDTH  = 256,
    parameter int C_AXIS_TUSER_WIDTH = 128,
    parameter int KEY_WIDTH          = 32,
    parameter int HDR_SKIP_BYTES     = 34,
    parameter int FIFO_DEPTH_BITS    = 2
) (
    input  logic                            axis_aclk,
    input  logic                            axis_reset,
    input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
    input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                            s_axis_tvalid,
    output logic                            s_axis_tready,
    input  logic                            s_axis_tlast,
    output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
    output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                            m_axis_tvalid,
    input  logic                            m_axis_tready,
    output logic                            m_axis_tlast,
    input  logic [KEY_WIDTH-1:0]            key_in,
    input  logic                            key_valid,
    input  logic                            enable,
    output logic [31:0]                     enc_pkt_count
);
    localparam int NB    = C_AXIS_DATA_WIDTH / 8;
    localparam int KB    = KEY_WIDTH / 8;
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    typedef enum logic {SOP, MID} state_t;

    logic [C_AXIS_DATA_WIDTH-1:0]  mem_data [DEPTH];
    logic [NB-1:0]                 mem_keep [DEPTH];
    logic [C_AXIS_TUSER_WIDTH-1:0] mem_user [DEPTH];
    logic                          mem_last [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0]    wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_BITS:0]      count;
    logic                          fifo_empty, fifo_nearly_full, wr, load;

    state_t                        state;
    logic [15:0]                   word_idx;
    logic [KEY_WIDTH-1:0]          pend_key, act_key, cur_key;
    logic                          act_enc, cur_enc, m_enc;
    logic [31:0]                   abs_base;
    logic [C_AXIS_DATA_WIDTH-1:0]  head_data, xor_data;
    logic [NB-1:0]                 head_keep;
    logic [C_AXIS_TUSER_WIDTH-1:0] head_user;
    logic                          head_last;

    assign fifo_empty       = count == '0;
    assign fifo_nearly_full = count >= (FIFO_DEPTH_BITS+1)'(DEPTH - 1);
    assign s_axis_tready    = !fifo_nearly_full;
    assign wr               = s_axis_tvalid && s_axis_tready;
    assign load             = !fifo_empty && (!m_axis_tvalid || m_axis_tready);

    assign head_data = mem_data[rd_ptr];
    assign head_keep = mem_keep[rd_ptr];
    assign head_user = mem_user[rd_ptr];
    assign head_last = mem_last[rd_ptr];

    always_ff @(posedge axis_aclk) begin
        if (wr) begin
            mem_data[wr_ptr] <= s_axis_tdata;
            mem_keep[wr_ptr] <= s_axis_tkeep;
            mem_user[wr_ptr] <= s_axis_tuser;
            mem_last[wr_ptr] <= s_axis_tlast;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr)
                wr_ptr <= wr_ptr + FIFO_DEPTH_BITS'(1);
            if (load)
                rd_ptr <= rd_ptr + FIFO_DEPTH_BITS'(1);
            count <= count + {{FIFO_DEPTH_BITS{1'b0}}, wr} - {{FIFO_DEPTH_BITS{1'b0}}, load};
        end
    end

    // A first word uses the pending key and live enable, which become active on its load
    assign cur_key  = (state == SOP) ? pend_key : act_key;
    assign cur_enc  = (state == SOP) ? enable : act_enc;
    assign abs_base = 32'(word_idx) * 32'(NB);

    // Data width is a multiple of the key width, so the key byte depends only on the lane
    for (genvar i = 0; i < NB; i++) begin : g_lane
        assign xor_data[8*i +: 8] = head_data[8*i +: 8] ^
            ((cur_enc && head_keep[i] && (abs_base + 32'(i) >= 32'(HDR_SKIP_BYTES)))
                ? cur_key[8*(i % KB) +: 8] : 8'h00);
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_reset) begin
            state         <= SOP;
            word_idx      <= '0;
            pend_key      <= '1;
            act_key       <= '1;
            act_enc       <= 1'b1;
            m_enc         <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tuser  <= '0;
            m_axis_tlast  <= 1'b0;
            enc_pkt_count <= '0;
        end else begin
            if (key_valid)
                pend_key <= key_in;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && m_enc)
                enc_pkt_count <= enc_pkt_count + 32'd1;
            if (load) begin
                m_axis_tdata  <= xor_data;
                m_axis_tkeep  <= head_keep;
                m_axis_tuser  <= head_user;
                m_axis_tlast  <= head_last;
                m_axis_tvalid <= 1'b1;
                m_enc         <= cur_enc;
                state         <= head_last ? SOP : MID;
                word_idx      <= head_last ? 16'd0 :
                                 (state == SOP) ? 16'd1 :
                                 (word_idx == 16'hFFFF) ? word_idx : word_idx + 16'd1;
                if (state == SOP) begin
                    act_key <= pend_key;
                    act_enc <= enable;
                end
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_axis_xor_cipher.sv
// tb_axis_xor_cipher: directed and randomized checks of axis_xor_cipher against a byte-level packet model
module tb_axis_xor_cipher;
    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = 32;
    localparam int NB = DW / 8;

    typedef struct {
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        logic [UW-1:0] u;
        logic          l;
    } word_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata, m_tdata;
    logic [NB-1:0] s_tkeep, m_tkeep;
    logic [UW-1:0] s_tuser, m_tuser;
    logic          s_tvalid, s_tready, s_tlast;
    logic          m_tvalid, m_tready, m_tlast;
    logic [KW-1:0] key_in;
    logic          key_valid, enable;
    logic [31:0]   enc_cnt;

    word_t exp_q[$], out_q[$];
    int    n_assert = 0, n_fail = 0, accepted = 0, exp_cnt = 0;
    bit    done;

    always #5 clk = ~clk;

    axis_xor_cipher dut (
        .axis_aclk(clk), .axis_reset(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tuser(s_tuser),
        .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tuser(m_tuser),
        .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .key_in(key_in), .key_valid(key_valid), .enable(enable), .enc_pkt_count(enc_cnt)
    );

    always @(posedge clk)
        if (!rst && m_tvalid && m_tready)
            out_q.push_back('{m_tdata, m_tkeep, m_tuser, m_tlast});

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
        n_assert++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    function automatic logic [DW-1:0] rand_wide();
        logic [DW-1:0] r;
        for (int j = 0; j < DW / 32; j++) r[32*j +: 32] = $urandom;
        return r;
    endfunction

    // Packet byte at absolute offset a is XORed with key byte a mod 4 when encrypting past the header
    function automatic logic [DW-1:0] model(input logic [DW-1:0] d, input logic [NB-1:0] k,
                                            input int w, input bit enc, input logic [KW-1:0] key);
        logic [DW-1:0] r;
        int a;
        r = d;
        for (int b = 0; b < NB; b++) begin
            a = w * NB + b;
            if (enc && a >= 34 && k[b]) r[8*b +: 8] = r[8*b +: 8] ^ key[8*(a % 4) +: 8];
        end
        return r;
    endfunction

    task automatic send_pkt(input int nw, input bit zero, input logic [NB-1:0] last_keep, input bit enc,
                            input logic [KW-1:0] key, input bit term, input int kv_at,
                            input logic [KW-1:0] kv_val);
        logic [DW-1:0] d;
        logic [NB-1:0] k;
        logic [UW-1:0] u;
        logic          l;
        int            n;
        for (int w = 0; w < nw; w++) begin
            d = zero ? '0 : rand_wide();
            k = (w == nw - 1) ? last_keep : '1;
            u = {$urandom, $urandom, $urandom, $urandom};
            l = term && (w == nw - 1);
            exp_q.push_back('{model(d, k, w, enc, key), k, u, l});
            s_tdata = d; s_tkeep = k; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
            if (w == kv_at) begin
                key_in = kv_val;
                key_valid = 1'b1;
            end
            n = 0;
            while (!s_tready && n < 300) begin
                @(negedge clk);
                n++;
            end
            chk("send_timeout", DW'(n < 300), DW'(1));
            @(negedge clk);
            accepted++;
            key_valid = 1'b0;
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        if (enc && term) exp_cnt++;
    endtask

    task automatic drain();
        int n;
        word_t o;
        n = 0;
        while (out_q.size() < exp_q.size() && n < 2000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("word_count", DW'(out_q.size()), DW'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            o = '{default: '0};
            if (i < out_q.size()) o = out_q[i];
            chk($sformatf("w%0d_data", i), o.d, exp_q[i].d);
            chk($sformatf("w%0d_keep", i), DW'(o.k), DW'(exp_q[i].k));
            chk($sformatf("w%0d_user", i), DW'(o.u), DW'(exp_q[i].u));
            chk($sformatf("w%0d_last", i), DW'(o.l), DW'(exp_q[i].l));
        end
        chk("enc_pkt_count", DW'(enc_cnt), DW'(exp_cnt));
    endtask

    task automatic clr();
        exp_q.delete();
        out_q.delete();
    endtask

    task automatic strobe_key(input logic [KW-1:0] k);
        key_in = k;
        key_valid = 1'b1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] hold;
        int            n;
        rst = 1'b1; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        m_tready = 1'b1; key_in = '0; key_valid = 1'b0; enable = 1'b1; done = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tvalid", DW'(m_tvalid), DW'(0));
        chk("rst_tdata", m_tdata, '0);
        chk("rst_tlast", DW'(m_tlast), DW'(0));
        chk("rst_count", DW'(enc_cnt), DW'(0));
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tready", DW'(s_tready), DW'(1));

        // Reset key (all ones), zero data, then a single-word packet
        send_pkt(3, 1, '1, 1, 32'hFFFFFFFF, 1, -1, '0);
        send_pkt(1, 1, '1, 1, 32'hFFFFFFFF, 1, -1, '0);
        drain();
        clr();

        // Last of two strobes wins
        strobe_key(32'hDEADBEEF);
        strobe_key(32'h04030201);
        send_pkt(2, 1, '1, 1, 32'h04030201, 1, -1, '0);
        drain();
        hold = (out_q.size() > 1) ? out_q[1].d : '1;
        chk("abs34_byte", DW'(hold[23:16]), DW'(8'h03));
        chk("abs36_byte", DW'(hold[39:32]), DW'(8'h01));
        chk("hdr_bytes", DW'(hold[15:0]), DW'(0));
        clr();

        // Partial tkeep on last word
        strobe_key(32'hFFFFFFFF);
        send_pkt(3, 1, 32'h0000000F, 1, 32'hFFFFFFFF, 1, -1, '0);
        drain();
        clr();

        // Bypass
        enable = 1'b0;
        send_pkt(3, 0, '1, 0, 32'hFFFFFFFF, 1, -1, '0);
        drain();
        clr();
        enable = 1'b1;

        // Key strobe coinciding with packet A's first-word load affects only packet B
        send_pkt(3, 0, '1, 1, 32'hFFFFFFFF, 1, 1, 32'h5A3CC396);
        send_pkt(3, 0, '1, 1, 32'h5A3CC396, 1, -1, '0);
        drain();
        clr();

        // Output stall mid-packet
        m_tready = 1'b0;
        accepted = 0;
        fork
            send_pkt(6, 0, '1, 1, 32'h5A3CC396, 1, -1, '0);
            begin
                n = 0;
                while (!m_tvalid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                hold = m_tdata;
                repeat (6) begin
                    @(negedge clk);
                    chk("stall_data", m_tdata, hold);
                    chk("stall_valid", DW'(m_tvalid), DW'(1));
                end
                chk("stall_tready", DW'(s_tready), DW'(0));
                chk("stall_accepted", DW'(accepted), DW'(4));
                m_tready = 1'b1;
            end
        join
        drain();
        clr();

        // 20 back-to-back random packets with random backpressure
        strobe_key(32'h9E3779B9);
        done = 1'b0;
        fork
            begin
                for (int p = 0; p < 20; p++)
                    send_pkt($urandom_range(1, 4), 0, NB'($urandom), 1, 32'h9E3779B9, 1, -1, '0);
                done = 1'b1;
            end
            while (!done) begin
                @(negedge clk);
                m_tready = $urandom_range(0, 3) != 0;
            end
        join
        m_tready = 1'b1;
        drain();
        clr();

        // Reset with a packet in flight, then a clean packet under the reset key
        m_tready = 1'b0;
        send_pkt(2, 0, '1, 1, 32'h9E3779B9, 0, -1, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_tvalid", DW'(m_tvalid), DW'(0));
        chk("midrst_count", DW'(enc_cnt), DW'(0));
        rst = 1'b0;
        m_tready = 1'b1;
        clr();
        exp_cnt = 0;
        send_pkt(3, 0, '1, 1, 32'hFFFFFFFF, 1, -1, '0);
        drain();
        clr();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
